// File: rtl/hyper_pkg.sv
// hyper_burst_splitter shared definitions:
// packed-command field offsets, mode codes, FSM states.
package hyper_pkg;

  localparam int TRANS_SIZE      = 16;
  localparam int TRANS_DATA_SIZE = 32 + TRANS_SIZE + 3 + 1;

  localparam int RX_BIT   = 4;
  localparam int SIZE_LSB = 5;
  localparam int SIZE_MSB = TRANS_SIZE + 4;
  localparam int ADDR_LSB = TRANS_SIZE + 5;
  localparam int ADDR_MSB = TRANS_DATA_SIZE - 1;
  localparam int ADDR_W   = ADDR_MSB - ADDR_LSB + 1;

  typedef logic [TRANS_SIZE-1:0] cnt_t;

  localparam logic [2:0] MODE_NORMAL = 3'd0;
  localparam logic [2:0] MODE_REG    = 3'd1;
  localparam logic [2:0] MODE_2D     = 3'd2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_ARG,
    ST_ISSUE,
    ST_DONE
  } state_t;

  function automatic cnt_t min_cnt(cnt_t a, cnt_t b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/hyper_burst_splitter_if.sv
// Burst command port towards the HyperBus PHY controller.
// valid/ready handshake; fields held stable while valid.
interface hyper_burst_splitter_if;
  import hyper_pkg::*;

  logic [31:0] addr;
  cnt_t        len;
  logic        rwn;
  logic        reg_acc;
  logic [15:0] reg_data;
  logic        last;
  logic        valid;
  logic        ready;

  modport master (
    output addr, len, rwn, reg_acc, reg_data, last, valid,
    input  ready
  );

  modport slave (
    input  addr, len, rwn, reg_acc, reg_data, last, valid,
    output ready
  );

endinterface

// File: rtl/hyper_burst_calc.sv
// Burst length: min(rem, row_rem, burst_max), fixed 2 for
// register access; last when the burst drains what is left.
module hyper_burst_calc
  import hyper_pkg::*;
(
  input  cnt_t rem,
  input  cnt_t row_rem,
  input  cnt_t burst_max,
  input  logic use_row,
  input  logic is_reg,
  output cnt_t len,
  output logic last
);

  cnt_t cap;

  // Clamp by row, then by burst cap (0 = unlimited).
  always_comb begin
    cap = use_row ? min_cnt(rem, row_rem) : rem;
    len = cap;
    if (burst_max != '0 && burst_max < cap) len = burst_max;
    if (is_reg) len = cnt_t'(2);
    last = is_reg || (len == rem);
  end

endmodule

// File: rtl/hyper_burst_splitter.sv
// Splits uDMA HyperBus transactions into PHY bursts
// (chip-select cap, 2D stride/line, register access).
module hyper_burst_splitter
  import hyper_pkg::*;
(
  input  logic                       clk_i,
  input  logic                       rstn_i,
  input  logic [TRANS_DATA_SIZE-1:0] trans_data_i,
  input  logic                       trans_valid_i,
  output logic                       trans_ready_o,
  input  logic [15:0]                arg_data_i,
  input  logic                       arg_valid_i,
  output logic                       arg_ready_o,
  input  cnt_t                       cfg_line_i,
  input  cnt_t                       cfg_burst_max_i,
  hyper_burst_splitter_if.master     burst,
  output logic                       trans_done_o,
  output logic                       trans_drop_o,
  output logic                       busy_o
);

  state_t      state;
  logic [31:0] addr_q;
  logic [31:0] row_base_q;
  cnt_t        rem_q;
  cnt_t        row_rem_q;
  logic [15:0] arg_q;
  logic        arg_vld;
  logic [15:0] targ_q;
  logic        rwn_q;
  logic        reg_q;
  logic        twod_q;
  logic        drop_q;

  logic [2:0]  cmd_mode;
  logic        cmd_rx;
  cnt_t        cmd_size;
  logic [31:0] cmd_addr;
  logic        cmd_reg;
  logic        cmd_2d;
  logic        cmd_arg;
  logic [15:0] arg_now;
  logic        arg_have;
  logic        arg_take;
  logic        issue;
  logic        hs;
  cnt_t        len;
  logic        last;
  cnt_t        rem_nxt;
  logic [31:0] row_nxt;
  logic        unused_mode_hi;

  assign cmd_mode = trans_data_i[2:0];
  assign cmd_rx   = trans_data_i[RX_BIT];
  assign cmd_size = trans_data_i[SIZE_MSB:SIZE_LSB];
  assign cmd_addr = {{(32-ADDR_W){1'b0}}, trans_data_i[ADDR_MSB:ADDR_LSB]};
  assign cmd_reg  = cmd_mode == MODE_REG;
  assign cmd_2d   = cmd_mode == MODE_2D;
  assign cmd_arg  = cmd_reg || cmd_2d;
  assign unused_mode_hi = trans_data_i[3];

  assign arg_now  = arg_valid_i ? arg_data_i : arg_q;
  assign arg_have = arg_valid_i || arg_vld;
  assign arg_take = (state == ST_IDLE && trans_valid_i && cmd_arg)
                 || (state == ST_WAIT_ARG && arg_valid_i);

  assign issue   = state == ST_ISSUE;
  assign hs      = issue && burst.ready;
  assign rem_nxt = rem_q - len;
  assign row_nxt = row_base_q + {16'b0, targ_q};

  hyper_burst_calc u_calc (
    .rem       (rem_q),
    .row_rem   (row_rem_q),
    .burst_max (cfg_burst_max_i),
    .use_row   (twod_q),
    .is_reg    (reg_q),
    .len       (len),
    .last      (last)
  );

  assign arg_ready_o   = 1'b1;
  assign trans_ready_o = state == ST_IDLE;
  assign busy_o        = state != ST_IDLE;
  assign trans_done_o  = state == ST_DONE;
  assign trans_drop_o  = drop_q;

  assign burst.valid    = issue;
  assign burst.addr     = issue ? addr_q : '0;
  assign burst.len      = issue ? len : '0;
  assign burst.rwn      = issue && rwn_q;
  assign burst.reg_acc  = issue && reg_q;
  assign burst.reg_data = (issue && reg_q) ? targ_q : '0;
  assign burst.last     = issue && last;

  // Sequencer: latch command, wait for argument, walk bursts.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state      <= ST_IDLE;
      addr_q     <= '0;
      row_base_q <= '0;
      rem_q      <= '0;
      row_rem_q  <= '0;
      arg_q      <= '0;
      arg_vld    <= 1'b0;
      targ_q     <= '0;
      rwn_q      <= 1'b0;
      reg_q      <= 1'b0;
      twod_q     <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      drop_q <= trans_valid_i && state != ST_IDLE;
      if (arg_valid_i) arg_q <= arg_data_i;
      if (arg_take) arg_vld <= 1'b0;
      else if (arg_valid_i) arg_vld <= 1'b1;
      unique case (state)
        ST_IDLE: begin
          if (trans_valid_i) begin
            addr_q     <= cmd_addr;
            row_base_q <= cmd_addr;
            rem_q      <= cmd_reg ? cnt_t'(2) : cmd_size;
            row_rem_q  <= min_cnt(cmd_size, cfg_line_i);
            targ_q     <= arg_now;
            rwn_q      <= cmd_rx;
            reg_q      <= cmd_reg;
            twod_q     <= cmd_2d && cfg_line_i != '0;
            if (cmd_arg && !arg_have) state <= ST_WAIT_ARG;
            else if (!cmd_reg && cmd_size == '0) state <= ST_DONE;
            else state <= ST_ISSUE;
          end
        end
        ST_WAIT_ARG: begin
          if (arg_valid_i) begin
            targ_q <= arg_data_i;
            if (!reg_q && rem_q == '0) state <= ST_DONE;
            else state <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (hs) begin
            if (last) begin
              rem_q <= '0;
              state <= ST_DONE;
            end else begin
              rem_q <= rem_nxt;
              if (twod_q && row_rem_q == len) begin
                row_base_q <= row_nxt;
                addr_q     <= row_nxt;
                row_rem_q  <= min_cnt(rem_nxt, cfg_line_i);
              end else begin
                addr_q    <= addr_q + {16'b0, len};
                row_rem_q <= row_rem_q - len;
              end
            end
          end
        end
        ST_DONE: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hyper_burst_splitter.sv
// Scoreboard bench for hyper_burst_splitter: expected bursts
// are queued at command time and popped on each handshake.
module tb_hyper_burst_splitter;
  import hyper_pkg::*;

  logic                       clk = 1'b0;
  logic                       rstn = 1'b0;
  logic [TRANS_DATA_SIZE-1:0] trans_data = '0;
  logic                       trans_valid = 1'b0;
  logic                       trans_ready;
  logic [15:0]                arg_data = '0;
  logic                       arg_valid = 1'b0;
  logic                       arg_ready;
  cnt_t                       cfg_line = '0;
  cnt_t                       cfg_bmax = '0;
  logic                       trans_done;
  logic                       trans_drop;
  logic                       busy;

  typedef struct packed {
    logic [31:0] addr;
    logic [15:0] len;
    logic        rwn;
    logic        rg;
    logic [15:0] data;
    logic        last;
  } bst_t;

  bst_t exp_q[$];
  int   checks = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  hyper_burst_splitter_if bif();

  hyper_burst_splitter dut (
    .clk_i           (clk),
    .rstn_i          (rstn),
    .trans_data_i    (trans_data),
    .trans_valid_i   (trans_valid),
    .trans_ready_o   (trans_ready),
    .arg_data_i      (arg_data),
    .arg_valid_i     (arg_valid),
    .arg_ready_o     (arg_ready),
    .cfg_line_i      (cfg_line),
    .cfg_burst_max_i (cfg_bmax),
    .burst           (bif),
    .trans_done_o    (trans_done),
    .trans_drop_o    (trans_drop),
    .busy_o          (busy)
  );

  function automatic logic [TRANS_DATA_SIZE-1:0] cmd(
    input logic [2:0] mode, input logic rx,
    input logic [15:0] size, input logic [30:0] addr);
    return {addr, size, rx, 1'b0, mode};
  endfunction

  function automatic bst_t act();
    return {bif.addr, bif.len, bif.rwn, bif.reg_acc,
            bif.reg_data, bif.last};
  endfunction

  function automatic logic [71:0] outs();
    return {bif.valid, bif.addr, bif.len, bif.rwn, bif.reg_acc,
            bif.reg_data, bif.last, trans_done, trans_drop, busy};
  endfunction

  function automatic void push(input logic [31:0] a,
    input logic [15:0] l, input logic rwn, input logic rg,
    input logic [15:0] d, input logic last);
    bst_t e;
    e = {a, l, rwn, rg, d, last};
    exp_q.push_back(e);
  endfunction

  task automatic send(input logic [TRANS_DATA_SIZE-1:0] c);
    int n = 0;
    while (!trans_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    trans_data  = c;
    trans_valid = 1'b1;
    @(negedge clk);
    trans_valid = 1'b0;
  endtask

  task automatic pulse_arg(input logic [15:0] d);
    arg_data  = d;
    arg_valid = 1'b1;
    @(negedge clk);
    arg_valid = 1'b0;
  endtask

  task automatic drain(input int stall, input int budget);
    int   cyc = 0;
    bit   seen = 0;
    bst_t e;
    bst_t a;
    while (cyc < budget) begin
      if (trans_done) begin
        seen = 1;
        break;
      end
      bif.ready = (cyc >= stall);
      if (bif.valid && bif.ready) begin
        a = act();
        checks++;
        if (exp_q.size() == 0)
          $display("FAIL extra_burst: got %h required none", a);
        else begin
          e = exp_q.pop_front();
          if (a !== e)
            $display("FAIL burst: got %h required %h", a, e);
          else passed++;
        end
      end
      @(negedge clk);
      cyc++;
    end
    bif.ready = 1'b0;
    checks++;
    if (!seen) $display("FAIL done_timeout: got 0 required 1");
    else passed++;
    checks++;
    if (exp_q.size() != 0)
      $display("FAIL leftover: got %0d required 0", exp_q.size());
    else passed++;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (outs() !== '0)
      $display("FAIL reset_outs: got %h required 0", outs());
    else passed++;
    checks++;
    if ({trans_ready, arg_ready} !== 2'b11)
      $display("FAIL reset_ready: got %b required 11",
               {trans_ready, arg_ready});
    else passed++;
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_normal();
    cfg_line = 16'd0;
    cfg_bmax = 16'd128;
    push(32'h1000, 16'd128, 0, 0, 16'h0, 0);
    push(32'h1080, 16'd128, 0, 0, 16'h0, 0);
    push(32'h1100, 16'd44,  0, 0, 16'h0, 1);
    send(cmd(MODE_NORMAL, 0, 16'd300, 31'h1000));
    checks++;
    if (bif.valid !== 1'b1)
      $display("FAIL normal_latency: got %b required 1", bif.valid);
    else passed++;
    drain(0, 40);
    @(negedge clk);
    checks++;
    if ({trans_ready, busy} !== 2'b10)
      $display("FAIL normal_idle: got %b required 10",
               {trans_ready, busy});
    else passed++;
  endtask

  task automatic test_2d();
    cfg_line = 16'd32;
    cfg_bmax = 16'd16;
    pulse_arg(16'h0100);
    push(32'h000, 16'd16, 1, 0, 16'h0, 0);
    push(32'h010, 16'd16, 1, 0, 16'h0, 0);
    push(32'h100, 16'd16, 1, 0, 16'h0, 0);
    push(32'h110, 16'd16, 1, 0, 16'h0, 1);
    send(cmd(MODE_2D, 1, 16'd64, 31'h0));
    drain(1, 40);
    cfg_line = 16'd0;
  endtask

  task automatic test_reg();
    cfg_bmax = 16'd16;
    pulse_arg(16'hBEEF);
    push(32'h800, 16'd2, 0, 1, 16'hBEEF, 1);
    send(cmd(MODE_REG, 0, 16'd0, 31'h800));
    drain(0, 20);
    @(negedge clk);
    send(cmd(MODE_REG, 1, 16'd0, 31'h804));
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({bif.valid, busy} !== 2'b01)
        $display("FAIL reg_wait: got %b required 01",
                 {bif.valid, busy});
      else passed++;
      @(negedge clk);
    end
    push(32'h804, 16'd2, 1, 1, 16'h1234, 1);
    pulse_arg(16'h1234);
    checks++;
    if (bif.valid !== 1'b1)
      $display("FAIL reg_arg_latency: got %b required 1", bif.valid);
    else passed++;
    drain(0, 20);
  endtask

  task automatic test_stall();
    bst_t want;
    cfg_bmax = 16'd0;
    want = {32'h3000, 16'd24, 1'b0, 1'b0, 16'h0, 1'b1};
    exp_q.push_back(want);
    send(cmd(MODE_NORMAL, 0, 16'd24, 31'h3000));
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (!bif.valid || act() !== want)
        $display("FAIL stall_hold: got %b/%h required 1/%h",
                 bif.valid, act(), want);
      else passed++;
      if (i == 1) begin
        trans_data  = cmd(MODE_NORMAL, 1, 16'd8, 31'h7000);
        trans_valid = 1'b1;
      end
      if (i == 2) begin
        trans_valid = 1'b0;
        checks++;
        if (trans_drop !== 1'b1)
          $display("FAIL drop_pulse: got %b required 1", trans_drop);
        else passed++;
      end
      if (i == 3) begin
        checks++;
        if (trans_drop !== 1'b0)
          $display("FAIL drop_width: got %b required 0", trans_drop);
        else passed++;
      end
      @(negedge clk);
    end
    drain(0, 20);
    repeat (3) begin
      @(negedge clk);
      checks++;
      if ({bif.valid, busy} !== 2'b00)
        $display("FAIL drop_effect: got %b required 00",
                 {bif.valid, busy});
      else passed++;
    end
  endtask

  task automatic test_zero_and_big();
    cfg_bmax = 16'd16;
    send(cmd(MODE_NORMAL, 0, 16'd0, 31'h2000));
    bif.ready = 1'b1;
    drain(0, 4);
    @(negedge clk);
    cfg_bmax = 16'd0;
    push(32'h10, 16'hFFFF, 1, 0, 16'h0, 1);
    send(cmd(MODE_NORMAL, 1, 16'hFFFF, 31'h10));
    drain(0, 20);
  endtask

  task automatic test_reset_mid();
    cfg_bmax = 16'd128;
    send(cmd(MODE_NORMAL, 0, 16'd300, 31'h4000));
    bif.ready = 1'b1;
    checks++;
    if (act() !== {32'h4000, 16'd128, 1'b0, 1'b0, 16'h0, 1'b0})
      $display("FAIL mid_first: got %h required 4000/128", act());
    else passed++;
    @(negedge clk);
    checks++;
    if (bif.addr !== 32'h4080)
      $display("FAIL mid_second: got %h required 4080", bif.addr);
    else passed++;
    rstn = 1'b0;
    #1;
    checks++;
    if (outs() !== '0 || {trans_ready, arg_ready} !== 2'b11)
      $display("FAIL mid_reset: got %h/%b required 0/11",
               outs(), {trans_ready, arg_ready});
    else passed++;
    bif.ready = 1'b0;
    @(negedge clk);
    checks++;
    if (outs() !== '0)
      $display("FAIL mid_reset_hold: got %h required 0", outs());
    else passed++;
    rstn = 1'b1;
    @(negedge clk);
    push(32'h5000, 16'd100, 0, 0, 16'h0, 1);
    send(cmd(MODE_NORMAL, 0, 16'd100, 31'h5000));
    drain(0, 20);
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bif.ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_normal();
    test_2d();
    test_reg();
    test_stall();
    test_zero_and_big();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
